// File: rtl/hpu_pkg.sv
// Shared constants and types for the HPU output-side stream path.
package hpu_pkg;

  localparam int DST_ADDR_W  = 5;
  localparam int AXIS_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One buffered stream beat: payload plus its end-of-frame flag.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic                   last;
  } axis_word_t;

endpackage

// File: rtl/dst_stream_ctrl_if.sv
// AXI4-Stream master/slave bundle for the dst_buf output stream.
interface dst_stream_ctrl_if #(
  parameter int DATA_W = 64
);

  logic              TVALID;
  logic              TREADY;
  logic [DATA_W-1:0] TDATA;
  logic              TLAST;

  modport master (
    output TVALID,
    output TDATA,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TVALID,
    input  TDATA,
    input  TLAST,
    output TREADY
  );

endinterface

// File: rtl/axis_skid_fifo.sv
// Two-entry registered FIFO holding returned dst_buf words until the
// stream sink accepts them. Head outputs come straight from storage.
module axis_skid_fifo
  import hpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  axis_word_t push_word,
  input  logic       pop,
  output logic [1:0] count,
  output axis_word_t head
);

  axis_word_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt_q;

  // Storage, pointers and occupancy; a push and pop together keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign count = cnt_q;
  assign head  = mem[rd_ptr];

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == 2'd2));

  no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && cnt_q == 2'd0));

endmodule

// File: rtl/dst_stream_ctrl.sv
// Read sequencer for the idle dst_buf bank and AXI4-Stream master.
// Issues one read per cycle while fewer than two words are buffered or in
// flight, captures the returned word a cycle later and streams it out.
module dst_stream_ctrl
  import hpu_pkg::*;
#(
  parameter int ADDR_W = DST_ADDR_W,
  parameter int DATA_W = AXIS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len_m1,
  output logic              busy,
  output logic              done,
  output logic              stream_v,
  output logic [ADDR_W-1:0] stream_a,
  input  logic [DATA_W-1:0] stream_d,
  dst_stream_ctrl_if.master m_axis
);

  state_t            state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W-1:0] ret_q;
  logic              inflight_q;

  logic [1:0]        fifo_count;
  axis_word_t        head;
  axis_word_t        push_word;
  logic              push;
  logic              pop;
  logic              tvalid;
  logic [2:0]        occupancy;

  assign tvalid = (fifo_count != 2'd0);
  assign pop    = tvalid & m_axis.TREADY;
  assign push   = inflight_q;

  // Read issue: words held plus in flight, less the beat leaving now, stay below two.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    stream_v  = (state_q == RUN) &&
                (issued_q <= {1'b0, len_q}) &&
                (occupancy < 3'd2);
    stream_a  = issued_q[ADDR_W-1:0];
    push_word = '{data: AXIS_DATA_W'(stream_d), last: (ret_q == len_q)};
  end

  // Control FSM, issue/return counters and the read-in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      ret_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= stream_v;
      if (stream_v) begin
        issued_q <= issued_q + 1'b1;
      end
      if (push) begin
        ret_q <= ret_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            len_q    <= len_m1;
            issued_q <= '0;
            ret_q    <= '0;
          end
        end
        RUN: begin
          if (pop && head.last) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  axis_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head)
  );

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign m_axis.TVALID = tvalid;
  assign m_axis.TDATA  = DATA_W'(head.data);
  assign m_axis.TLAST  = head.last;

endmodule

// File: tb/tb_dst_stream_ctrl.sv
// Directed scenarios with randomized TREADY and dst_buf idle noise, checked
// against a word-sequence reference: beat i must carry word i of the bank.
module tb_dst_stream_ctrl;
  import hpu_pkg::*;

  localparam int ADDR_W = DST_ADDR_W;
  localparam int DATA_W = AXIS_DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] len_m1;
  logic              busy;
  logic              done;
  logic              stream_v;
  logic [ADDR_W-1:0] stream_a;
  logic [DATA_W-1:0] stream_d;

  int checks = 0;
  int errors = 0;

  dst_stream_ctrl_if #(.DATA_W(DATA_W)) axis_if ();

  dst_stream_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len_m1   (len_m1),
    .busy     (busy),
    .done     (done),
    .stream_v (stream_v),
    .stream_a (stream_a),
    .stream_d (stream_d),
    .m_axis   (axis_if)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_at(input int a);
    return 64'hA000_0000_0000_0000 | 64'(a);
  endfunction

  // dst_buf model: addressed word one cycle after a read, noise otherwise.
  always @(posedge clk) begin
    stream_d <= stream_v ? word_at(int'(stream_a)) : {$urandom, $urandom};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: TREADY high after 'stall' cycles; mode 1: random TREADY.
  // restart_beat/reset_beat < 0 disable the extra start pulse / reset.
  task automatic xfer(input int len, input int mode, input int stall,
                      input int restart_beat, input int reset_beat);
    int   cyc       = 0;
    int   pulses    = 0;
    int   beats     = 0;
    int   final_cyc = -1;
    int   done_cyc  = -1;
    int   done_cnt  = 0;
    bit   restarted = 0;
    logic prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic rdy;
    logic pop;

    len_m1 = ADDR_W'(len);
    start  = 1'b1;
    axis_if.TREADY = 1'b0;
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;

    forever begin
      if (cyc > 400) begin
        check("timeout", 64'd1, 64'd0);
        break;
      end
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;

      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc >= stall);
      axis_if.TREADY = rdy;
      start = 1'b0;
      if (restart_beat >= 0 && !restarted && beats == restart_beat) begin
        start     = 1'b1;
        len_m1    = ADDR_W'(3);
        restarted = 1;
      end

      if (reset_beat >= 0 && beats == reset_beat) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        axis_if.TREADY = 1'b1;
        #1;
        check("rst_tvalid", 64'(axis_if.TVALID), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stream_v", 64'(stream_v), 64'd0);
        tick();
        check("rst_stale_tvalid", 64'(axis_if.TVALID), 64'd0);
        check("rst_done2", 64'(done), 64'd0);
        return;
      end

      #1;
      pop = axis_if.TVALID & rdy;

      if (cyc == 0) check("first_stream_v", 64'(stream_v), 64'd1);
      if (cyc <= 2) check("first_tvalid", 64'(axis_if.TVALID), 64'(cyc == 2));

      if (stream_v) begin
        check("stream_a", 64'(stream_a), 64'(pulses));
        pulses++;
      end
      check("outstanding_le2", 64'((pulses - beats - int'(pop)) <= 2), 64'd1);

      if (prev_stall) begin
        check("hold_tvalid", 64'(axis_if.TVALID), 64'd1);
        check("hold_tdata", axis_if.TDATA, prev_data);
        check("hold_tlast", 64'(axis_if.TLAST), 64'(prev_last));
      end

      check("done", 64'(done), 64'(final_cyc >= 0 && cyc == final_cyc + 1));
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end

      if (final_cyc < 0 || cyc <= final_cyc) check("busy_high", 64'(busy), 64'd1);
      else if (done_cyc >= 0 && cyc > done_cyc) check("busy_low", 64'(busy), 64'd0);

      if (pop) begin
        check("tdata", axis_if.TDATA, word_at(beats));
        check("tlast", 64'(axis_if.TLAST), 64'(beats == len));
        if (beats == len) final_cyc = cyc;
        beats++;
      end

      if (stall > 0 && cyc == stall - 1) check("stall_pulses", 64'(pulses), 64'd2);

      prev_stall = axis_if.TVALID & ~rdy;
      prev_data  = axis_if.TDATA;
      prev_last  = axis_if.TLAST;
      tick();
      cyc++;
    end

    check("beat_count", 64'(beats), 64'(len + 1));
    check("read_count", 64'(pulses), 64'(len + 1));
    check("done_count", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    len_m1 = '0;
    axis_if.TREADY = 1'b0;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stream_v", 64'(stream_v), 64'd0);
    check("reset_stream_a", 64'(stream_a), 64'd0);
    check("reset_tvalid", 64'(axis_if.TVALID), 64'd0);
    check("reset_tlast", 64'(axis_if.TLAST), 64'd0);
    check("reset_tdata", axis_if.TDATA, 64'd0);
    rst = 1'b0;
    tick();

    xfer(31, 0, 0, -1, -1);   // full bank, free flow
    xfer(31, 1, 0, -1, -1);   // random backpressure
    xfer(31, 0, 20, -1, -1);  // long initial stall
    xfer(0, 0, 0, -1, -1);    // single word
    xfer(15, 0, 0, 5, -1);    // start pulse while busy
    xfer(31, 0, 0, -1, 10);   // reset mid-stream
    xfer(3, 0, 0, -1, -1);    // clean restart after reset
    xfer(31, 1, 0, -1, -1);   // second random backpressure pass

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
